fir_mac_ctrl: RTL

FIR_MAC_CTRL -- requirements
Module: fir_mac_ctrl

---
 rtl/fir_mac_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/fir_mac_ctrl.sv
// FIR filter sequencer: delay line, coefficient bank and tap loop
// driving an external multiply-accumulate ALU, one tap per cycle.
module fir_mac_ctrl #(
  parameter int NTAPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        coef_wr,
  input  logic [3:0]  coef_addr,
  input  logic [15:0] coef_data,
  output logic [15:0] alu_x,
  output logic [15:0] alu_b,
  output logic [38:0] alu_sum_in,
  input  logic [38:0] alu_sum_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [38:0] out_data
);

  localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [TW-1:0] LAST = TW'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]   x_q [NTAPS];
  logic [15:0]   c_q [NTAPS];
  logic [TW-1:0] tap_q;
  logic [38:0]   acc_q;

  logic accept;
  logic coef_we;
  logic in_mac;

  assign in_mac  = (state_q == MAC);
  assign accept  = in_valid && (state_q == IDLE);
  assign coef_we = coef_wr && (state_q == IDLE)
                && (int'(coef_addr) < NTAPS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = MAC;
      MAC:  if (tap_q == LAST) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == OUT);
    out_data   = acc_q;
    alu_sum_in = acc_q;
    alu_x      = '0;
    alu_b      = '0;
    if (in_mac) begin
      alu_x = x_q[tap_q];
      alu_b = c_q[tap_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      // same-edge write lands before the first MAC cycle reads it
      if (coef_we) c_q[coef_addr[TW-1:0]] <= coef_data;
      if (accept) begin
        for (int i = NTAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
        x_q[0] <= in_data;
        acc_q  <= '0;
        tap_q  <= '0;
      end else if (in_mac) begin
        acc_q <= alu_sum_out;
        tap_q <= tap_q + TW'(1);
      end
    end
  end

endmodule
